multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over 3-5 cycles per instruction.
- Drives `immsrc` to the immediate extender (`00` I, `01` S, `10` B, `11` J) and drives the ALU, memory, register-file and PC enables.
- Sits beside the shared datapath: one ALU, one unified memory port, IR/ALUOut/Data registers.

Parameters:
- `RESET_STATE`, `4'd0` (FETCH), state entered on reset; kept for bring-up/debug only.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  7  `instr[6:0]` from IR.
- `funct3`  in  3  `instr[14:12]`.
- `funct7b5`  in  1  `instr[30]`.
- `zero`  in  1  ALU zero flag.
- `pcwrite`  out  1  PC load enable.
- `adrsrc`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `memwrite`  out  1  memory write strobe.
- `irwrite`  out  1  IR load enable.
- `resultsrc`  out  2  result mux: `00` ALUOut, `01` Data, `10` ALUResult.
- `alusrca`  out  2  ALU A: `00` PC, `01` OldPC, `10` rs1.
- `alusrcb`  out  2  ALU B: `00` rs2, `01` ImmExt, `10` const 4.
- `alucontrol`  out  3  `000` add, `001` sub, `010` and, `011` or, `101` slt.
- `immsrc`  out  2  immediate format select.
- `regwrite`  out  1  register-file write strobe.
- `illegal`  out  1  one-cycle pulse on unsupported opcode.

Behaviour:
- Single clock `clk`; reset is synchronous and active-high, named `reset`. On reset the state register goes to FETCH at the next edge.
- While `reset` = 1, `pcwrite`, `irwrite`, `memwrite`, `regwrite` and `illegal` are forced 0. Other outputs are don't-care but driven to 0.
- Moore FSM; outputs decode from the state only, except:
  - `pcwrite` = `pcupdate` | (`branch` & `zero`).
  - `immsrc` and `alucontrol` also decode from instruction fields.
- `immsrc`, combinational from `op` in every state:
  - `0000011`, `0010011` → `00`
  - `0100011` → `01`
  - `1100011` → `10`
  - `1101111` → `11`
  - otherwise `00`.
- `aluop` is internal:
  - `00` → add.
  - `01` → sub.
  - `10` → decode by `funct3`:
    - `000`: sub if `op[5]` & `funct7b5`, else add.
    - `010`: slt.
    - `110`: or.
    - `111`: and.
    - other `funct3`: add.
- States, with active outputs (unlisted = 0), and transitions:
  - FETCH: `adrsrc`=0, `irwrite`=1, `alusrca`=00, `alusrcb`=10, `aluop`=00, `resultsrc`=10, `pcupdate`=1 → DECODE.
  - DECODE: `alusrca`=01, `alusrcb`=01, `aluop`=00 (branch target to ALUOut). Next state by `op`:
    - lw/sw → MEMADR
    - R (`0110011`) → EXECUTER
    - I-ALU (`0010011`) → EXECUTEI
    - beq (`1100011`) → BEQ
    - jal (`1101111`) → JAL
    - else → FETCH, with `illegal`=1 in this DECODE cycle.
  - MEMADR: `alusrca`=10, `alusrcb`=01, `aluop`=00 → MEMREAD if `op`=`0000011`, else MEMWRITE.
  - MEMREAD: `resultsrc`=00, `adrsrc`=1 → MEMWB.
  - MEMWB: `resultsrc`=01, `regwrite`=1 → FETCH.
  - MEMWRITE: `resultsrc`=00, `adrsrc`=1, `memwrite`=1 → FETCH.
  - EXECUTER: `alusrca`=10, `alusrcb`=00, `aluop`=10 → ALUWB.
  - EXECUTEI: `alusrca`=10, `alusrcb`=01, `aluop`=10 → ALUWB.
  - ALUWB: `resultsrc`=00, `regwrite`=1 → FETCH.
  - BEQ: `alusrca`=10, `alusrcb`=00, `aluop`=01, `resultsrc`=00, `branch`=1 → FETCH.
  - JAL: `alusrca`=01, `alusrcb`=10, `aluop`=00, `resultsrc`=00, `pcupdate`=1 → ALUWB.
- Cycle counts, FETCH to next FETCH:
  - lw 5
  - sw 4
  - R/I 4
  - beq 3
  - jal 4
  - illegal 2
- Unused state encodings → FETCH on the next edge; no strobes asserted.
- Reset mid-instruction: next edge is FETCH regardless of state; no partial write completes after the reset edge.

Optional Feature:
- Macro: `MULTICYCLE_CTRL_BNE_EN`.
- Defined:
  - In BEQ, `branch` qualifies on `funct3`: `000` → `zero`; `001` → !`zero`; others → no branch.
  - DECODE still routes opcode `1100011` to BEQ.
- Undefined:
  - `funct3` ignored in BEQ; every `1100011` is treated as beq.

Test Plan:
- Reset: hold `reset`=1 for 3 cycles in MEMWRITE → `memwrite`=0 throughout; first cycle after release shows FETCH (`irwrite`=1, `pcwrite`=1, `alusrcb`=10).
- lw x6,-4(x9) (`0xFFC4A303`) → 5 cycles.
  - `immsrc`=00.
  - MEMREAD `adrsrc`=1.
  - MEMWB `resultsrc`=01, `regwrite`=1.
- sw x6,8(x9) (`0x0064A423`) → 4 cycles.
  - `immsrc`=01.
  - `memwrite`=1 only in cycle 4, `adrsrc`=1.
- sub x4,x2,x1 (`0x40110233`) → `alucontrol`=001 in EXECUTER; or x4,x5,x6 (`0x0062E233`) → 011; `regwrite`=1 in cycle 4.
- beq x4,x4,+8 (`0x00420463`) with `zero`=1 → `immsrc`=10, `pcwrite`=1 in cycle 3. Same instruction with `zero`=0 → `pcwrite`=0.
  - With `MULTICYCLE_CTRL_BNE_EN` defined: bne (`0x00421463`) with `zero`=0 → `pcwrite`=1.
- jal x1,+16 (`0x010000EF`) → `immsrc`=11; JAL `pcwrite`=1; ALUWB `regwrite`=1. Opcode `0x0000007F` → `illegal` pulse in DECODE, back in FETCH on the next cycle.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle RV32I datapath (master) and its controller (slave).
// The datapath supplies instruction fields and the ALU zero flag; the controller returns enables and mux selects.
`timescale 1ns/1ps

interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] immsrc;
    logic       regwrite;
    logic       illegal;

    modport master (
        output op, funct3, funct7b5, zero,
        input  pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
               alucontrol, immsrc, regwrite, illegal
    );

    modport slave (
        input  op, funct3, funct7b5, zero,
        output pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
               alucontrol, immsrc, regwrite, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback over 3-5 cycles.
// Optional macro MULTICYCLE_CTRL_BNE_EN lets the BEQ state also resolve bne via funct3.
`timescale 1ns/1ps

module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic logic [1:0] imm_decode(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_LOAD, OP_ITYPE: imm = 2'b00;
            OP_STORE:          imm = 2'b01;
            OP_BRANCH:         imm = 2'b10;
            OP_JAL:            imm = 2'b11;
            default:           imm = 2'b00;
        endcase
        return imm;
    endfunction

    function automatic logic [2:0] alu_decode(input logic [1:0] aluop, input logic [2:0] funct3,
                                              input logic op5, input logic funct7b5);
        logic [2:0] ctl;
        case (aluop)
            2'b00: ctl = 3'b000;
            2'b01: ctl = 3'b001;
            2'b10: begin
                case (funct3)
                    // Only R-type (op[5]=1) turns funct7b5 into sub; addi with imm[10]=1 stays add.
                    3'b000:  ctl = (op5 & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ctl = 3'b101;
                    3'b110:  ctl = 3'b011;
                    3'b111:  ctl = 3'b010;
                    default: ctl = 3'b000;
                endcase
            end
            default: ctl = 3'b000;
        endcase
        return ctl;
    endfunction

    function automatic logic op_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t     state_q;
    state_t     state_d;

    logic       pcupdate_s;
    logic       branch_s;
    logic       taken_s;
    logic       adrsrc_s;
    logic       memwrite_s;
    logic       irwrite_s;
    logic       regwrite_s;
    logic       illegal_s;
    logic [1:0] resultsrc_s;
    logic [1:0] alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] aluop_s;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= state_t'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LOAD) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore decode of the per-state control word; unused encodings assert nothing.
    always_comb begin
        pcupdate_s  = 1'b0;
        branch_s    = 1'b0;
        adrsrc_s    = 1'b0;
        memwrite_s  = 1'b0;
        irwrite_s   = 1'b0;
        regwrite_s  = 1'b0;
        illegal_s   = 1'b0;
        resultsrc_s = 2'b00;
        alusrca_s   = 2'b00;
        alusrcb_s   = 2'b00;
        aluop_s     = 2'b00;
        case (state_q)
            S_FETCH: begin
                irwrite_s   = 1'b1;
                alusrcb_s   = 2'b10;
                resultsrc_s = 2'b10;
                pcupdate_s  = 1'b1;
            end
            S_DECODE: begin
                alusrca_s = 2'b01;
                alusrcb_s = 2'b01;
                illegal_s = ~op_supported(bus.op);
            end
            S_MEMADR: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
            end
            S_MEMREAD: begin
                adrsrc_s = 1'b1;
            end
            S_MEMWB: begin
                resultsrc_s = 2'b01;
                regwrite_s  = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc_s   = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECUTER: begin
                alusrca_s = 2'b10;
                aluop_s   = 2'b10;
            end
            S_EXECUTEI: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
                aluop_s   = 2'b10;
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
            end
            S_BEQ: begin
                alusrca_s = 2'b10;
                aluop_s   = 2'b01;
                branch_s  = 1'b1;
            end
            S_JAL: begin
                alusrca_s  = 2'b01;
                alusrcb_s  = 2'b10;
                pcupdate_s = 1'b1;
            end
            default: begin
                pcupdate_s = 1'b0;
            end
        endcase
    end

    // Branch condition; the ALU has already computed rs1 - rs2 when BEQ is active.
    always_comb begin
        taken_s = 1'b0;
`ifdef MULTICYCLE_CTRL_BNE_EN
        case (bus.funct3)
            3'b000:  taken_s = bus.zero;
            3'b001:  taken_s = ~bus.zero;
            default: taken_s = 1'b0;
        endcase
`else
        taken_s = bus.zero;
`endif
    end

    // Output stage: reset forces every output low so no strobe leaks during reset.
    always_comb begin
        bus.pcwrite    = 1'b0;
        bus.adrsrc     = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.resultsrc  = 2'b00;
        bus.alusrca    = 2'b00;
        bus.alusrcb    = 2'b00;
        bus.alucontrol = 3'b000;
        bus.immsrc     = 2'b00;
        bus.regwrite   = 1'b0;
        bus.illegal    = 1'b0;
        if (reset) begin
            bus.pcwrite = 1'b0;
        end else begin
            bus.pcwrite    = pcupdate_s | (branch_s & taken_s);
            bus.adrsrc     = adrsrc_s;
            bus.memwrite   = memwrite_s;
            bus.irwrite    = irwrite_s;
            bus.resultsrc  = resultsrc_s;
            bus.alusrca    = alusrca_s;
            bus.alusrcb    = alusrcb_s;
            bus.alucontrol = alu_decode(aluop_s, bus.funct3, bus.op[5], bus.funct7b5);
            bus.immsrc     = imm_decode(bus.op);
            bus.regwrite   = regwrite_s;
            bus.illegal    = illegal_s;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each step queues stimulus with its expected control word,
// and the task draining the queue compares the DUT outputs at the falling edge of that cycle.
`timescale 1ns/1ps

module tb_multicycle_ctrl;

    logic clk;
    logic reset;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [31:0] instr;
        logic        zero;
        logic [16:0] exp;
    } step_t;

    step_t sb_q[$];
    string tag_q[$];
    int    n_cmp;
    int    n_err;

    logic [16:0] act_v;
    assign act_v = {bus.pcwrite, bus.adrsrc, bus.memwrite, bus.irwrite, bus.resultsrc,
                    bus.alusrca, bus.alusrcb, bus.alucontrol, bus.immsrc, bus.regwrite, bus.illegal};

    localparam logic [31:0] I_LW   = 32'hFFC4A303;
    localparam logic [31:0] I_SW   = 32'h0064A423;
    localparam logic [31:0] I_SUB  = 32'h40110233;
    localparam logic [31:0] I_OR   = 32'h0062E233;
    localparam logic [31:0] I_AND  = 32'h0062F233;
    localparam logic [31:0] I_ADDI = 32'h40010093;
    localparam logic [31:0] I_SLTI = 32'h00512093;
    localparam logic [31:0] I_BEQ  = 32'h00420463;
    localparam logic [31:0] I_BNE  = 32'h00421463;
    localparam logic [31:0] I_JAL  = 32'h010000EF;
    localparam logic [31:0] I_ILL  = 32'h0000007F;
    localparam logic [16:0] E_ZERO = 17'h00000;

    function automatic logic [16:0] ev(input logic pcw, input logic adr, input logic mw, input logic ir,
                                       input logic [1:0] rs, input logic [1:0] asa, input logic [1:0] asb,
                                       input logic [2:0] alu, input logic [1:0] imm,
                                       input logic rw, input logic ill);
        return {pcw, adr, mw, ir, rs, asa, asb, alu, imm, rw, ill};
    endfunction

    function automatic logic [16:0] e_fetch(input logic [1:0] imm);
        return ev(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, 1'b0);
    endfunction

    function automatic logic [16:0] e_decode(input logic [1:0] imm, input logic ill);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0, ill);
    endfunction

    task automatic step(input logic rst, input logic [31:0] instr, input logic zero,
                        input logic [16:0] exp, input string tag);
        step_t s;
        s.rst   = rst;
        s.instr = instr;
        s.zero  = zero;
        s.exp   = exp;
        sb_q.push_back(s);
        tag_q.push_back(tag);
    endtask

    task automatic apply(input step_t s);
        reset        = s.rst;
        bus.op       = s.instr[6:0];
        bus.funct3   = s.instr[14:12];
        bus.funct7b5 = s.instr[30];
        bus.zero     = s.zero;
    endtask

    task automatic test_reset();
        step_t s;
        string t;
        for (int i = 0; i < 2; i++) step(1'b1, I_SW, 1'b0, E_ZERO, "reset hold");
        step(1'b0, I_SW, 1'b0, e_fetch(2'b01), "sw fetch");
        step(1'b0, I_SW, 1'b0, e_decode(2'b01, 1'b0), "sw decode");
        step(1'b0, I_SW, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 1'b0, 1'b0), "sw memadr");
        for (int i = 0; i < 3; i++) step(1'b1, I_SW, 1'b0, E_ZERO, "reset in memwrite");
        step(1'b0, I_SW, 1'b0, e_fetch(2'b01), "fetch after reset");
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            t = tag_q.pop_front();
            apply(s);
            @(negedge clk);
            n_cmp++;
            if (act_v !== s.exp) begin
                n_err++;
                $display("FAIL %s: got %05h expected %05h", t, act_v, s.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_store();
        step_t s;
        string t;
        step(1'b0, I_SW, 1'b0, e_decode(2'b01, 1'b0), "sw decode");
        step(1'b0, I_SW, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 1'b0, 1'b0), "sw memadr");
        step(1'b0, I_SW, 1'b0, ev(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0), "sw memwrite");
        step(1'b0, I_LW, 1'b0, e_fetch(2'b00), "lw fetch");
        step(1'b0, I_LW, 1'b0, e_decode(2'b00, 1'b0), "lw decode");
        step(1'b0, I_LW, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0), "lw memadr");
        step(1'b0, I_LW, 1'b0, ev(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0), "lw memread");
        step(1'b0, I_LW, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0), "lw memwb");
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            t = tag_q.pop_front();
            apply(s);
            @(negedge clk);
            n_cmp++;
            if (act_v !== s.exp) begin
                n_err++;
                $display("FAIL %s: got %05h expected %05h", t, act_v, s.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_alu();
        step_t s;
        string t;
        logic [31:0] instrs [5] = '{I_SUB, I_OR, I_AND, I_ADDI, I_SLTI};
        logic [2:0]  ctl    [5] = '{3'b001, 3'b011, 3'b010, 3'b000, 3'b101};
        logic [1:0]  srcb   [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, instrs[i], 1'b1, e_fetch(2'b00), $sformatf("alu%0d fetch", i));
            step(1'b0, instrs[i], 1'b1, e_decode(2'b00, 1'b0), $sformatf("alu%0d decode", i));
            step(1'b0, instrs[i], 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, srcb[i], ctl[i], 2'b00, 1'b0, 1'b0),
                 $sformatf("alu%0d execute", i));
            step(1'b0, instrs[i], 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0),
                 $sformatf("alu%0d aluwb", i));
        end
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            t = tag_q.pop_front();
            apply(s);
            @(negedge clk);
            n_cmp++;
            if (act_v !== s.exp) begin
                n_err++;
                $display("FAIL %s: got %05h expected %05h", t, act_v, s.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        step_t s;
        string t;
        logic [31:0] instrs [4] = '{I_BEQ, I_BEQ, I_BNE, I_BNE};
        logic        zeros  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
`ifdef MULTICYCLE_CTRL_BNE_EN
        logic        taken  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        logic        taken  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
`endif
        for (int i = 0; i < 4; i++) begin
            step(1'b0, instrs[i], zeros[i], e_fetch(2'b10), $sformatf("br%0d fetch", i));
            step(1'b0, instrs[i], zeros[i], e_decode(2'b10, 1'b0), $sformatf("br%0d decode", i));
            step(1'b0, instrs[i], zeros[i],
                 ev(taken[i], 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0, 1'b0),
                 $sformatf("br%0d beq", i));
        end
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            t = tag_q.pop_front();
            apply(s);
            @(negedge clk);
            n_cmp++;
            if (act_v !== s.exp) begin
                n_err++;
                $display("FAIL %s: got %05h expected %05h", t, act_v, s.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        string t;
        step(1'b0, I_JAL, 1'b0, e_fetch(2'b11), "jal fetch");
        step(1'b0, I_JAL, 1'b0, e_decode(2'b11, 1'b0), "jal decode");
        step(1'b0, I_JAL, 1'b0, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 1'b0, 1'b0), "jal jal");
        step(1'b0, I_JAL, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1'b1, 1'b0), "jal aluwb");
        step(1'b0, I_ILL, 1'b0, e_fetch(2'b00), "ill fetch");
        step(1'b0, I_ILL, 1'b0, e_decode(2'b00, 1'b1), "ill decode");
        step(1'b0, I_ILL, 1'b0, e_fetch(2'b00), "ill refetch");
        step(1'b0, I_ILL, 1'b0, e_decode(2'b00, 1'b1), "ill decode2");
        step(1'b0, I_SW, 1'b0, e_fetch(2'b01), "sw after ill");
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            t = tag_q.pop_front();
            apply(s);
            @(negedge clk);
            n_cmp++;
            if (act_v !== s.exp) begin
                n_err++;
                $display("FAIL %s: got %05h expected %05h", t, act_v, s.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset        = 1'b1;
        bus.op       = 7'd0;
        bus.funct3   = 3'd0;
        bus.funct7b5 = 1'b0;
        bus.zero     = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_store();
        test_alu();
        test_branch();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
